alu_arbiter: RTL and testbench

- Shares one alu instance between N requesters.
- Round-robin grant, at most one op issued per cycle, no bubbles.
- Tracks each in-flight op's requester ID through the fixed alu latency and routes the result back as a one-hot response.
- Sits between the requester-side logic and the alu; the top level drives the alu's active-high rst from ~rst_n.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/alu_arb_rr_pick.sv | 35 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the alu arbiter slice.
package alu_arb_pkg;

   localparam int OP_W        = 2;
   localparam int ALU_LAT_DEF = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } operation_t;

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Rotating-priority picker: first set bit of req_i at or after ptr_i, wrapping modulo N.
// Purely combinational; reports one-hot grant, its index and whether anything was picked.
module alu_arb_rr_pick
   import alu_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] idx_o,
   output logic           any_o
);

   logic [IDW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr_i) + k) % N);
         if (req_i[cand]) begin
            gnt_o       = '0;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU_LAT-cycle alu among N requesters; results return as one-hot rsp after ALU_LAT cycles.
// No backpressure on responses; ALU_ARBITER_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int WIDTH   = 6,
   parameter int ALU_LAT = ALU_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req_valid,
   input  logic [OP_W*N-1:0]   req_op,
   input  logic [WIDTH*N-1:0]  req_a,
   input  logic [WIDTH*N-1:0]  req_b,
   output logic [N-1:0]        req_ready,
   input  logic                hold,
   output logic [OP_W-1:0]     alu_op,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   output logic                alu_in_valid,
   input  logic [WIDTH-1:0]    alu_out,
   input  logic                alu_out_valid,
   output logic [N-1:0]        rsp_valid,
   output logic [WIDTH-1:0]    rsp_data,
   output logic                busy,
`ifdef ALU_ARBITER_STATS_EN
   output logic [16*N-1:0]     stat_grants,
`endif
   output logic                err
);

   localparam int IDW  = $clog2(N);
   localparam int LAST = ALU_LAT - 1;

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           err_q, err_d;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;

   logic [ALU_LAT-1:0] tag_vld_q;
   logic [IDW-1:0]     tag_id_q [ALU_LAT];

   alu_arb_rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req_i (hold ? '0 : req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign req_ready    = gnt;
   assign alu_in_valid = gnt_any;
   assign busy         = |tag_vld_q;
   assign err          = err_q;

   always_comb begin
      alu_op = OP_NOP;
      alu_a  = '0;
      alu_b  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            alu_op = req_op[OP_W*i +: OP_W];
            alu_a  = req_a[WIDTH*i +: WIDTH];
            alu_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      rsp_valid = '0;
      rsp_data  = '0;
      if (gnt_any) begin
         ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // A response is only trusted when the tag and the alu agree.
      if (tag_vld_q[LAST] && alu_out_valid) begin
         rsp_valid[tag_id_q[LAST]] = 1'b1;
         rsp_data                  = alu_out;
      end
      err_d = err_q | (tag_vld_q[LAST] ^ alu_out_valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         err_q     <= 1'b0;
         tag_vld_q <= '0;
         for (int i = 0; i < ALU_LAT; i++) tag_id_q[i] <= '0;
      end else begin
         ptr_q        <= ptr_d;
         err_q        <= err_d;
         tag_vld_q[0] <= gnt_any;
         tag_id_q[0]  <= gnt_idx;
         for (int i = 1; i < ALU_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

`ifdef ALU_ARBITER_STATS_EN
   logic [15:0] grant_cnt_q [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) grant_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (gnt[i] && (grant_cnt_q[i] != 16'hFFFF)) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < N; i++) stat_grants[16*i +: 16] = grant_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N=4, WIDTH=6, ALU_LAT=2) driving a behavioural two-stage alu.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [7:0]  req_op;
   logic [23:0] req_a;
   logic [23:0] req_b;
   logic [3:0]  req_ready;
   logic        hold;
   logic [1:0]  alu_op;
   logic [5:0]  alu_a, alu_b, alu_out;
   logic        alu_in_valid, alu_out_valid;
   logic [3:0]  rsp_valid;
   logic [5:0]  rsp_data;
   logic        busy, err;
   logic        force_ov;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(4), .WIDTH(6), .ALU_LAT(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_ready     (req_ready),
      .hold          (hold),
      .alu_op        (alu_op),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_in_valid  (alu_in_valid),
      .alu_out       (alu_out),
      .alu_out_valid (alu_out_valid),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .err           (err)
   );

   // Behavioural alu: result registered twice, active-high reset from ~rst_n.
   logic       alu_rst;
   logic       s1_v, s2_v;
   logic [5:0] s1_r, s2_r;
   assign alu_rst = ~rst_n;

   always_ff @(posedge clk or posedge alu_rst) begin
      if (alu_rst) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_r <= '0; s2_r <= '0;
      end else begin
         s1_v <= alu_in_valid;
         case (alu_op)
            2'd1:    s1_r <= alu_a + alu_b;
            2'd2:    s1_r <= alu_a - alu_b;
            default: s1_r <= '0;
         endcase
         s2_v <= s1_v;
         s2_r <= s1_r;
      end
   end

   assign alu_out_valid = s2_v | force_ov;
   assign alu_out       = s2_r;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
      req_op[2*i +: 2] = op;
      req_a[6*i +: 6]  = a;
      req_b[6*i +: 6]  = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One isolated request: grant in cycle 0, response in cycle 2.
   task automatic single_op(input string tag, input int i, input logic [1:0] op,
                            input logic [5:0] a, input logic [5:0] b, input logic [5:0] exp);
      set_req(i, op, a, b);
      req_valid = 4'(1 << i);
      @(negedge clk);
      check_eq({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
      check_eq({tag, "_inv"}, 32'(alu_in_valid), 32'd1);
      tick();
      req_valid = '0;
      @(negedge clk);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check_eq({tag, "_rsp_vld"}, 32'(rsp_valid), 32'(1 << i));
      check_eq({tag, "_rsp_dat"}, 32'(rsp_data), 32'(exp));
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      hold = 1'b0; force_ov = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_vld", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_dat", 32'(rsp_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_inv", 32'(alu_in_valid), 32'd0);
      tick();
      rst_n = 1'b1;

      // Basic add from requester 2
      single_op("add53", 2, OP_ADD, 6'd5, 6'd3, 6'd8);
      @(negedge clk);
      check_eq("drain_busy", 32'(busy), 32'd0);
      tick();

      // Fairness: all requesters valid for 8 cycles after a fresh reset
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 6'(i), 6'd10);
      for (int k = 0; k < 10; k++) begin
         req_valid = (k < 8) ? 4'hF : 4'h0;
         @(negedge clk);
         if (k < 8) check_eq("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
         if (k >= 2) begin
            check_eq("rr_rsp_vld", 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
            check_eq("rr_rsp_dat", 32'(rsp_data), 32'(((k - 2) % 4) + 10));
         end
         tick();
      end

      // Wrap-around arithmetic and nop
      single_op("sub25", 1, OP_SUB, 6'd2, 6'd5, 6'h3D);
      single_op("add63", 1, OP_ADD, 6'd63, 6'd1, 6'd0);
      single_op("nop", 0, OP_NOP, 6'd7, 6'd9, 6'd0);

      // Hold while an op drains; rr_ptr is 1 so requester 3 wins first
      set_req(0, OP_ADD, 6'd1, 6'd1);
      set_req(3, OP_ADD, 6'd4, 6'd4);
      req_valid = 4'b1001;
      @(negedge clk);
      check_eq("hold_pre_grant", 32'(req_ready), 32'h8);
      tick();
      hold = 1'b1;
      @(negedge clk);
      check_eq("hold_c1_ready", 32'(req_ready), 32'd0);
      check_eq("hold_c1_inv", 32'(alu_in_valid), 32'd0);
      check_eq("hold_c1_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check_eq("hold_c2_ready", 32'(req_ready), 32'd0);
      check_eq("hold_c2_busy", 32'(busy), 32'd1);
      check_eq("hold_c2_rsp_vld", 32'(rsp_valid), 32'h8);
      check_eq("hold_c2_rsp_dat", 32'(rsp_data), 32'd8);
      tick();
      @(negedge clk);
      check_eq("hold_c3_ready", 32'(req_ready), 32'd0);
      check_eq("hold_c3_busy", 32'(busy), 32'd0);
      check_eq("hold_c3_rsp_vld", 32'(rsp_valid), 32'd0);
      tick();
      hold = 1'b0;
      @(negedge clk);
      check_eq("hold_resume", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      check_eq("hold_resume_rsp_vld", 32'(rsp_valid), 32'h1);
      check_eq("hold_resume_rsp_dat", 32'(rsp_data), 32'd2);
      tick();

      // Reset one cycle after a grant discards the in-flight op
      set_req(2, OP_ADD, 6'd1, 6'd2);
      req_valid = 4'b0100;
      @(negedge clk);
      check_eq("mid_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      @(negedge clk);
      check_eq("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_err", 32'(err), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("mid_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      check_eq("mid_err_after", 32'(err), 32'd0);

      // Spurious alu_out_valid with an empty tag pipe
      force_ov = 1'b1;
      @(negedge clk);
      check_eq("flt_rsp", 32'(rsp_valid), 32'd0);
      check_eq("flt_err_before", 32'(err), 32'd0);
      tick();
      force_ov = 1'b0;
      @(negedge clk);
      check_eq("flt_err_set", 32'(err), 32'd1);
      check_eq("flt_rsp_after", 32'(rsp_valid), 32'd0);
      tick();
      tick();
      @(negedge clk);
      check_eq("flt_err_sticky", 32'(err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
